// File: rtl/double_mul_operand_feeder_if.sv
// Handshake bundle between an operand producer, the feeder and the multiplier's
// two operand ports.
interface double_mul_operand_feeder_if;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        in_stb;
    logic        in_ack;
    logic [63:0] mul_a;
    logic        mul_a_stb;
    logic        mul_a_ack;
    logic [63:0] mul_b;
    logic        mul_b_stb;
    logic        mul_b_ack;

    modport slave (
        input  in_a, in_b, in_stb, mul_a_ack, mul_b_ack,
        output in_ack, mul_a, mul_a_stb, mul_b, mul_b_stb
    );

    modport master (
        output in_a, in_b, in_stb, mul_a_ack, mul_b_ack,
        input  in_ack, mul_a, mul_a_stb, mul_b, mul_b_stb
    );
endinterface

// File: rtl/double_mul_operand_feeder.sv
// Buffers (a, b) operand pairs in a FIFO and replays each pair onto the
// multiplier's input_a then input_b stb/ack handshakes.
//
// state  | meaning
// IDLE   | nothing held; waiting for a queued pair
// SEND_A | held pair's a offered on mul_a (mul_a_stb=1)
// SEND_B | held pair's b offered on mul_b (mul_b_stb=1)
module double_mul_operand_feeder #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    double_mul_operand_feeder_if.slave bus,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   level,
    output logic [31:0]              issued_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    typedef enum logic [1:0] {IDLE, SEND_A, SEND_B} state_t;

    state_t          state, state_d;
    logic [127:0]    mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   cnt;
    logic [63:0]     a_hold, b_hold;
    logic            a_stb, b_stb;
    logic            a_stb_d, b_stb_d;
    logic [31:0]     count_q;
    logic            push, pop, can_pop, a_done, b_done;

    assign bus.in_ack    = rst & ~flush & (cnt != FULL);
    assign push          = bus.in_stb & bus.in_ack;
    assign can_pop       = ~flush & (cnt != '0);
    assign a_done        = a_stb & bus.mul_a_ack;
    assign b_done        = b_stb & bus.mul_b_ack;

    assign bus.mul_a     = a_hold;
    assign bus.mul_b     = b_hold;
    assign bus.mul_a_stb = a_stb;
    assign bus.mul_b_stb = b_stb;
    assign level         = cnt;
    assign issued_count  = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (can_pop) state_d = SEND_A;
            SEND_A:  if (a_done)  state_d = SEND_B;
            SEND_B:  if (b_done)  state_d = can_pop ? SEND_A : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A pop loads the holding registers whenever a fresh pair enters SEND_A.
    always_comb begin
        pop     = 1'b0;
        a_stb_d = (state_d == SEND_A);
        b_stb_d = (state_d == SEND_B);
        if (state_d == SEND_A && state != SEND_A) pop = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            a_hold  <= '0;
            b_hold  <= '0;
            a_stb   <= 1'b0;
            b_stb   <= 1'b0;
            count_q <= '0;
        end else begin
            a_stb <= a_stb_d;
            b_stb <= b_stb_d;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                cnt <= cnt + LW'(push) - LW'(pop);
            end
            if (pop) {a_hold, b_hold} <= mem[rd_ptr];
            if (b_done) count_q <= count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.in_a, bus.in_b};
    end
endmodule

// File: tb/tb_double_mul_operand_feeder.sv
// Scoreboard bench: drivers queue expected pairs on accepted pushes, a negedge
// monitor checks the replayed a/b stream, level and issued_count.
module tb_double_mul_operand_feeder;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  level;
    logic [31:0] issued_count;

    double_mul_operand_feeder_if bus();

    double_mul_operand_feeder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bus), .flush(flush),
        .level(level), .issued_count(issued_count)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [127:0] exp_q[$];
    logic [63:0] cur_b;
    bit          cur_valid = 0;
    logic [31:0] model_count = 0;
    int          a_x_cyc[$];
    int          b_x_cyc[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: values are stable at the negedge and describe the coming edge.
    always @(negedge clk) begin
        int model_level;
        cyc++;
        if (!rst) begin
            exp_q.delete();
            cur_valid   = 0;
            model_count = 0;
            check("rst_outputs", {bus.mul_a_stb, bus.mul_b_stb, bus.in_ack, level},
                  64'd0);
            check("rst_count", issued_count, 64'd0);
        end else begin
            model_level = exp_q.size() - (bus.mul_a_stb ? 1 : 0);
            check("strobe_excl", bus.mul_a_stb & bus.mul_b_stb, 64'd0);
            check("level", level, 64'(model_level));
            check("issued_count", issued_count, model_count);
            check("in_ack", bus.in_ack, (!flush && model_level != DEPTH));
            if (bus.mul_a_stb) begin
                if (exp_q.size() == 0) fail_now("unexpected_a_stb");
                else begin
                    check("mul_a", bus.mul_a, exp_q[0][127:64]);
                    if (bus.mul_a_ack) begin
                        cur_b     = exp_q[0][63:0];
                        cur_valid = 1;
                        void'(exp_q.pop_front());
                        a_x_cyc.push_back(cyc);
                    end
                end
            end
            if (bus.mul_b_stb) begin
                if (!cur_valid) fail_now("unexpected_b_stb");
                else begin
                    check("mul_b", bus.mul_b, cur_b);
                    if (bus.mul_b_ack) begin
                        cur_valid   = 0;
                        model_count = model_count + 32'd1;
                        b_x_cyc.push_back(cyc);
                    end
                end
            end
            if (flush) begin
                if (bus.mul_a_stb && !bus.mul_a_ack && exp_q.size() > 0) begin
                    logic [127:0] head;
                    head = exp_q[0];
                    exp_q.delete();
                    exp_q.push_back(head);
                end else exp_q.delete();
            end
        end
    end

    // Call at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic push_pair(input logic [63:0] a, input logic [63:0] b, output int edge_cyc);
        int t;
        bus.in_a   = a;
        bus.in_b   = b;
        bus.in_stb = 1'b1;
        t = 0;
        edge_cyc = -1;
        forever begin
            @(negedge clk);
            #1;
            if (bus.in_ack) break;
            t++;
            if (t > 200) begin
                fail_now("push_timeout");
                bus.in_stb = 1'b0;
                return;
            end
        end
        @(posedge clk);
        exp_q.push_back({a, b});
        edge_cyc = cyc + 1;
        #1;
        bus.in_stb = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !cur_valid && !bus.mul_a_stb && !bus.mul_b_stb) break;
            t++;
            if (t > 400) begin
                fail_now("drain_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.mul_a_ack = 1'b1;
        bus.mul_b_ack = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("in_ack_in_reset", bus.in_ack, 64'd0);
        rst = 1'b1;
        #1;
        check("in_ack_after_release", bus.in_ack, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic single_pair(input string tag);
        int p;
        int na;
        int nb;
        na = a_x_cyc.size();
        nb = b_x_cyc.size();
        push_pair(64'h4000000000000000, 64'h4008000000000000, p);
        wait_drain();
        check({tag, "_a_xfers"}, 64'(a_x_cyc.size() - na), 64'd1);
        check({tag, "_b_xfers"}, 64'(b_x_cyc.size() - nb), 64'd1);
        if (a_x_cyc.size() > na && b_x_cyc.size() > nb) begin
            check({tag, "_a_latency"}, 64'(a_x_cyc[na]), 64'(p + 1));
            check({tag, "_b_follows_a"}, 64'(b_x_cyc[nb]), 64'(p + 2));
        end
        check({tag, "_count"}, issued_count, 64'd1);
    endtask

    initial begin
        int p;
        bit rdone;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_stb = 1'b0;
        bus.mul_a_ack = 1'b1;
        bus.mul_b_ack = 1'b1;

        // Single pair after reset
        do_reset();
        single_pair("single");

        // Fill and stall
        do_reset();
        bus.mul_a_ack = 1'b0;
        for (int i = 0; i < 5; i++)
            push_pair({32'hA0A0_0000, 32'(i)}, {32'hB0B0_0000, 32'(i)}, p);
        @(negedge clk);
        #1;
        check("fill_level", level, 64'd4);
        check("fill_in_ack", bus.in_ack, 64'd0);
        @(posedge clk);
        #1;
        fork
            push_pair({32'hA0A0_0000, 32'd5}, {32'hB0B0_0000, 32'd5}, p);
            begin
                repeat (3) @(posedge clk);
                #2;
                check("held_off_6th", bus.in_ack, 64'd0);
                bus.mul_a_ack = 1'b1;
            end
        join
        wait_drain();
        check("fill_count", issued_count, 64'd6);

        // Stream throughput
        begin
            int na;
            int nb;
            na = a_x_cyc.size();
            nb = b_x_cyc.size();
            for (int i = 0; i < 8; i++)
                push_pair({$urandom, $urandom}, {$urandom, $urandom}, p);
            wait_drain();
            check("stream_b_xfers", 64'(b_x_cyc.size() - nb), 64'd8);
            if (b_x_cyc.size() - nb == 8 && a_x_cyc.size() - na == 8) begin
                check("stream_span", 64'(b_x_cyc[nb + 7] - a_x_cyc[na]), 64'd15);
                for (int i = 0; i < 7; i++)
                    check("stream_no_bubble", 64'(a_x_cyc[na + i + 1] - b_x_cyc[nb + i]), 64'd1);
            end
            check("stream_count", issued_count, 64'd14);
        end

        // Flush with a pair in flight
        do_reset();
        bus.mul_b_ack = 1'b0;
        for (int i = 0; i < 3; i++)
            push_pair({32'hF1F1_0000, 32'(i)}, {32'hF2F2_0000, 32'(i)}, p);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        #1;
        check("flush_level", level, 64'd0);
        check("flush_b_held", bus.mul_b_stb, 64'd1);
        check("flush_b_data", bus.mul_b, 64'hF2F2_0000_0000_0000);
        @(posedge clk);
        #1;
        bus.mul_b_ack = 1'b1;
        wait_drain();
        repeat (4) @(posedge clk);
        #1;
        check("flush_idle", {bus.mul_a_stb, bus.mul_b_stb}, 64'd0);
        check("flush_count", issued_count, 64'd1);

        // Randomised pushes against random acks
        rdone = 0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    push_pair({$urandom, $urandom}, {$urandom, $urandom}, p);
                end
                rdone = 1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk);
                    #1;
                    bus.mul_a_ack = 1'($urandom_range(0, 1));
                    bus.mul_b_ack = 1'($urandom_range(0, 1));
                end
                bus.mul_a_ack = 1'b1;
                bus.mul_b_ack = 1'b1;
            end
        join
        wait_drain();
        check("random_count", issued_count, 64'd31);

        // Asynchronous reset while mul_a_stb is high
        bus.mul_a_ack = 1'b0;
        push_pair(64'h1111, 64'h2222, p);
        @(posedge clk);
        #2;
        check("pre_reset_a_stb", bus.mul_a_stb, 64'd1);
        rst = 1'b0;
        #1;
        check("async_a_stb", bus.mul_a_stb, 64'd0);
        check("async_level", level, 64'd0);
        check("async_in_ack", bus.in_ack, 64'd0);
        check("async_mul_a", bus.mul_a, 64'd0);
        do_reset();
        single_pair("after_reset");

        // issued_count wrap
        force dut.count_q = 32'hFFFF_FFFF;
        model_count = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        @(posedge clk);
        #1;
        push_pair(64'h3FF0000000000000, 64'hBFF0000000000000, p);
        wait_drain();
        check("count_wrap", issued_count, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/double_mul_operand_feeder.md
# double_mul_operand_feeder

Upstream operand-staging stage for `double_multiplier`. It accepts operand pairs (a, b) from a producer over a single stb/ack handshake and buffers them in a DEPTH-entry FIFO. It then replays each pair onto the multiplier's separate `input_a` and `input_b` stb/ack handshakes, always a first, then b. It is the block that lets a test or system producer push pairs back-to-back without tracking the multiplier's two-phase operand protocol.

## Interface
- `DEPTH`, default 4: FIFO entries; must be a power of two, ≥ 2.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `in_a`  in  64  — operand a of the pushed pair (IEEE-754 double bits, opaque to this block).
- `in_b`  in  64  — operand b of the pushed pair.
- `in_stb`  in  1  — producer offers a pair.
- `in_ack`  out  1  — feeder can accept; push occurs on an edge where `in_stb` and `in_ack` are both 1.
- `mul_a`  out  64  — to multiplier `input_a`.
- `mul_a_stb`  out  1  — to multiplier `input_a_stb`.
- `mul_a_ack`  in  1  — from multiplier `input_a_ack`.
- `mul_b`  out  64  — to multiplier `input_b`.
- `mul_b_stb`  out  1  — to multiplier `input_b_stb`.
- `mul_b_ack`  in  1  — from multiplier `input_b_ack`.
- `flush`  in  1  — synchronous discard of all queued, not-yet-popped pairs.
- `level`  out  $clog2(DEPTH)+1  — number of queued pairs. The pair currently held for transmission is excluded.
- `issued_count`  out  32  — count of pairs whose b transfer has completed; wraps modulo 2^32.

## Operation
- **FIFO.** DEPTH entries of 128 bits ({a, b}). Read and write pointers are $clog2(DEPTH) bits and wrap naturally. `level` is a registered counter.
  - `in_ack` = `rst` & ~`flush` & (`level` != DEPTH). It is combinational from the registered `level`.
- **FSM states.** IDLE, SEND_A, SEND_B.
  - IDLE: if `level` > 0 and ~`flush`, pop the head into holding registers `a_hold`/`b_hold`, set `mul_a_stb`=1, go to SEND_A. Otherwise stay in IDLE.
  - SEND_A: on an edge with `mul_a_stb` & `mul_a_ack`, set `mul_a_stb`=0, set `mul_b_stb`=1, go to SEND_B.
  - SEND_B: on an edge with `mul_b_stb` & `mul_b_ack`, set `mul_b_stb`=0 and increment `issued_count`.
    - If `level` > 0 and ~`flush` on the same edge, pop the next pair, set `mul_a_stb`=1 and go to SEND_A.
    - Otherwise go to IDLE.
- **Output data.** `mul_a` = `a_hold` and `mul_b` = `b_hold`. Both are stable for the whole time their stb is high; they change only on a pop.
- **Exclusive strobes.** `mul_a_stb` and `mul_b_stb` are registered and never both 1.
- **Push and pop on the same edge.** Both happen; `level` is unchanged. When full, `in_ack`=0, so no push occurs even if a pop happens that edge.
- **Flush.** On an edge with `flush`=1:
  - pointers and `level` go to 0;
  - no push and no pop occur;
  - the pair already in `a_hold`/`b_hold` continues through SEND_A/SEND_B unaffected;
  - `issued_count` is not cleared.
- **Reset.** `rst`=0, including mid-transfer, immediately forces:
  - state IDLE;
  - `mul_a_stb`=`mul_b_stb`=0, `mul_a`=`mul_b`=0;
  - `level`=0, pointers 0, `issued_count`=0, `in_ack`=0.
  - Queued and in-flight pairs are lost.

## Timing
- **Reset values.** `in_ack`=0 while `rst`=0, and 1 from the first moment `rst`=1. All other outputs are 0.
- **Empty-FIFO latency.** Push at edge N gives `level`=1 after N. The pop happens at edge N+1, so `mul_a_stb` rises after N+1 and `level` returns to 0 at the same time.
- **Per-pair cost.** With `mul_*_ack` held high, one pair takes 2 edges: the a transfer, then the b transfer. Back-to-back pairs give `mul_a_stb` high in the cycle right after a b transfer, with no IDLE bubble.
- **Stalls.** `mul_a_ack` or `mul_b_ack` low holds the current stb and data indefinitely. The FIFO keeps accepting until full.
- **Count update.** `issued_count` updates on the same edge as the b transfer.

## Test plan
- **Single pair.** Reset, then push {0x4000000000000000, 0x4008000000000000} with both acks high.
  - `mul_a_stb` is high for exactly 1 cycle with `mul_a`=0x4000000000000000.
  - Next cycle, `mul_b_stb` is high with `mul_b`=0x4008000000000000.
  - `issued_count`=1.
- **Fill and stall.** DEPTH=4, `mul_a_ack`=0. Push 6 pairs.
  - 1 pair goes to the holding register and 4 are queued.
  - `in_ack` drops when `level`=4; the 6th push is held off.
  - Release `mul_a_ack`: all pairs are delivered in push order, a before b, and `issued_count`=6.
- **Stream throughput.** Acks high, 8 pairs pushed back-to-back.
  - `mul_a_stb` and `mul_b_stb` alternate with no idle cycle.
  - 8 b transfers complete in 16 consecutive edges.
- **Flush with pair in flight.** 3 pairs pushed, first pair in SEND_B with `mul_b_ack`=0; pulse `flush` for 1 cycle.
  - `level`=0.
  - The first pair still completes on `mul_b_ack`, then the FSM returns to IDLE.
  - `issued_count`=1.
- **Asynchronous reset mid-transfer.** Assert `rst`=0 between edges while `mul_a_stb`=1.
  - `mul_a_stb`=0, `level`=0 and `in_ack`=0 without waiting for a clock edge.
  - After release, a new push behaves exactly as in the single-pair scenario.
- **Count wrap.** Force `issued_count` to 0xFFFFFFFF, then complete one pair: `issued_count`=0.
